// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer: state encodings
// and the bit-counter width helper.
package piso_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Counter must index bits 0..width-1; never narrower than one bit.
  function automatic int piso_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Mod-WIDTH bit counter for the serializer: enable, synchronous zero, async
// active-low clear, and a terminal-count flag marking the last bit of a word.
module piso_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic clear_n,
  input  logic en,
  input  logic zero,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  assign tc = (count == LAST);

  // Wraps from WIDTH-1 straight to 0 so a reloaded word starts at bit 0.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load and gapless streaming
// of back-to-back words. Define PISO_LSB_FIRST_EN to emit bit 0 first (default MSB first).
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             x,
  output logic             x_valid,
  output logic             x_last
);

  localparam int CW = piso_cnt_width(WIDTH);

  logic             state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             tc;
  logic             in_shift;
  logic             advance;
  logic             accept;

  assign in_shift   = (state == ST_SHIFT);
  assign advance    = in_shift & shift_en;
  assign x_last     = in_shift & tc;
  assign load_ready = (state == ST_IDLE) | (x_last & shift_en);
  assign accept     = load_valid & load_ready;
  assign x_valid    = in_shift;

  // The shift register is cleared on leaving SHIFT, so x reads 0 while idle.
`ifdef PISO_LSB_FIRST_EN
  assign x          = shift_reg[0];
  assign shift_next = {1'b0, shift_reg[WIDTH-1:1]};
`else
  assign x          = shift_reg[WIDTH-1];
  assign shift_next = {shift_reg[WIDTH-2:0], 1'b0};
`endif

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .clear_n (clear_n),
    .en      (advance),
    .zero    ((state == ST_IDLE) & accept),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        state     <= ST_SHIFT;
        shift_reg <= load_data;
      end
    end else if (shift_en) begin
      if (!tc) begin
        shift_reg <= shift_next;
      end else if (accept) begin
        shift_reg <= load_data;
      end else begin
        state     <= ST_IDLE;
        shift_reg <= '0;
      end
    end
  end

endmodule
